// File: rtl/drive_rddata_gen_pkg.sv
// Shared constants and state encoding for the drive read-data emulator.
package drive_rddata_gen_pkg;

    localparam int BIT_CELL_CLKS_DEF = 28;
    localparam int PULSE_CLKS_DEF    = 7;
    localparam int SYNC_CELLS        = 10;

    localparam logic [SYNC_CELLS-1:0] SYNC_PATTERN = 10'b1111111100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SYNC  = 2'd2
    } state_t;

endpackage

// File: rtl/drive_rddata_gen_pulse.sv
// RDDATA pulse generator: times each bit cell and shapes a PULSE_CLKS-wide low pulse
// at the start of every '1' cell.
module drive_rddata_gen_pulse #(
    parameter int BIT_CELL_CLKS = 28,
    parameter int PULSE_CLKS    = 7
) (
    input  logic fclk,
    input  logic _reset,
    input  logic run,
    input  logic cell_bit,
    output logic cell_end,
    output logic rddata
);

    localparam int CW = $clog2(BIT_CELL_CLKS);
    localparam int PW = (PULSE_CLKS > 1) ? $clog2(PULSE_CLKS) : 1;

    logic [CW-1:0] cell_cnt;
    logic [PW-1:0] pulse_left;
    logic          cell_start;

    assign cell_start = run && (cell_cnt == '0);
    assign cell_end   = run && (cell_cnt == CW'(BIT_CELL_CLKS - 1));

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            cell_cnt <= '0;
        end else if (!run || cell_end) begin
            cell_cnt <= '0;
        end else begin
            cell_cnt <= cell_cnt + 1'b1;
        end
    end

    // Once started a pulse always runs its full width, even if run drops, so no runt pulses.
    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            rddata     <= 1'b1;
            pulse_left <= '0;
        end else if (cell_start && cell_bit) begin
            rddata     <= 1'b0;
            pulse_left <= PW'(PULSE_CLKS - 1);
        end else if (pulse_left != '0) begin
            pulse_left <= pulse_left - 1'b1;
        end else begin
            rddata     <= 1'b1;
        end
    end

endmodule

// File: rtl/drive_rddata_gen.sv
// Drive-side RDDATA emulator: accepts GCR nibbles over valid/ready and serializes them MSB first.
// Define DRIVE_RDDATA_SYNC_FILL_EN to pad underruns with 10-cell self-sync groups instead of idling.
module drive_rddata_gen
    import drive_rddata_gen_pkg::*;
#(
    parameter int BIT_CELL_CLKS = BIT_CELL_CLKS_DEF,
    parameter int PULSE_CLKS    = PULSE_CLKS_DEF
) (
    input  logic       fclk,
    input  logic       _reset,
    input  logic       enable,
    input  logic [7:0] nib_data,
    input  logic       nib_valid,
    output logic       nib_ready,
    output logic       rddata,
    output logic       busy,
    output logic       underrun
);

    state_t     state, state_nxt;
    logic [7:0] hold_data;
    logic [7:0] shifter;
    logic [2:0] bit_idx;
    logic       hold_full;
    logic       load_shift;
    logic       accept;
    logic       run;
    logic       cell_bit;
    logic       cell_end;
`ifdef DRIVE_RDDATA_SYNC_FILL_EN
    logic [3:0]            sync_idx;
    logic [SYNC_CELLS-1:0] sync_pat;

    assign sync_pat = SYNC_PATTERN;
`endif

    assign run       = enable && (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign nib_ready = !hold_full || load_shift;
    assign accept    = nib_valid && nib_ready;

    always_comb begin
        cell_bit = shifter[bit_idx];
`ifdef DRIVE_RDDATA_SYNC_FILL_EN
        if (state == ST_SYNC) begin
            cell_bit = sync_pat[4'd9 - sync_idx];
        end
`endif
    end

    // Byte (or sync group) boundaries reload straight from holding so there is never a gap cell.
    always_comb begin
        state_nxt  = state;
        load_shift = 1'b0;
        underrun   = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        load_shift = 1'b1;
                        state_nxt  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cell_end && (bit_idx == 3'd0)) begin
                        if (hold_full) begin
                            load_shift = 1'b1;
                        end else begin
                            underrun = 1'b1;
`ifdef DRIVE_RDDATA_SYNC_FILL_EN
                            state_nxt = ST_SYNC;
`else
                            state_nxt = ST_IDLE;
`endif
                        end
                    end
                end
`ifdef DRIVE_RDDATA_SYNC_FILL_EN
                ST_SYNC: begin
                    if (cell_end && (sync_idx == 4'd9)) begin
                        if (hold_full) begin
                            load_shift = 1'b1;
                            state_nxt  = ST_SHIFT;
                        end else begin
                            underrun = 1'b1;
                        end
                    end
                end
`endif
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= nib_data;
            hold_full <= 1'b1;
        end else if (load_shift) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            shifter <= '0;
            bit_idx <= '0;
        end else if (load_shift) begin
            shifter <= hold_data;
            bit_idx <= 3'd7;
        end else if (state_nxt == ST_IDLE) begin
            bit_idx <= '0;
        end else if ((state == ST_SHIFT) && cell_end && (bit_idx != 3'd0)) begin
            bit_idx <= bit_idx - 1'b1;
        end
    end

`ifdef DRIVE_RDDATA_SYNC_FILL_EN
    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            sync_idx <= '0;
        end else if ((state != ST_SYNC) || (state_nxt != ST_SYNC)) begin
            sync_idx <= '0;
        end else if (cell_end) begin
            sync_idx <= (sync_idx == 4'd9) ? 4'd0 : sync_idx + 1'b1;
        end
    end
`endif

    drive_rddata_gen_pulse #(
        .BIT_CELL_CLKS (BIT_CELL_CLKS),
        .PULSE_CLKS    (PULSE_CLKS)
    ) u_pulse (
        .fclk     (fclk),
        ._reset   (_reset),
        .run      (run),
        .cell_bit (cell_bit),
        .cell_end (cell_end),
        .rddata   (rddata)
    );

endmodule

// File: tb/tb_drive_rddata_gen.sv
// Self-checking bench for drive_rddata_gen: table of single nibbles plus directed multi-cycle sequences.
// Expectations follow DRIVE_RDDATA_SYNC_FILL_EN when the bench is built with it.
module tb_drive_rddata_gen;

    typedef struct {
        logic [7:0] nib;
        int         pulses;
        int         last_off;
    } vec_t;

    logic       fclk = 1'b0;
    logic       _reset;
    logic       enable;
    logic [7:0] nib_data;
    logic       nib_valid;
    logic       nib_ready;
    logic       rddata;
    logic       busy;
    logic       underrun;

    int   checks = 0;
    int   errors = 0;
    logic cells[$];
    int   ur_pos[$];
    int   fall_pos[$];
    int   rd_err;
    int   fall_limit;
    int   busy_gaps;
    logic prev_rd;
    vec_t vecs[6];

`ifdef DRIVE_RDDATA_SYNC_FILL_EN
    localparam logic BUSY_TAIL = 1'b1;
`else
    localparam logic BUSY_TAIL = 1'b0;
`endif

    drive_rddata_gen dut (
        .fclk      (fclk),
        ._reset    (_reset),
        .enable    (enable),
        .nib_data  (nib_data),
        .nib_valid (nib_valid),
        .nib_ready (nib_ready),
        .rddata    (rddata),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 fclk = ~fclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not end (got timeout, expected finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected rddata n cycles after the load edge: pulses lag the cell counter by one register stage.
    function automatic logic exp_rd(input int n);
        int   m;
        logic b;
        if (n < 1) return 1'b1;
        m = n - 1;
        b = ((m / 28) < cells.size()) ? cells[m / 28] : 1'b0;
        return !(b && ((m % 28) < 7));
    endfunction

    task automatic push_nib(input logic [7:0] nib);
        for (int i = 7; i >= 0; i--) cells.push_back(nib[i]);
    endtask

    task automatic push_sync(input int groups);
        logic [9:0] sp;
        sp = 10'b1111111100;
        for (int g = 0; g < groups; g++)
            for (int i = 9; i >= 0; i--) cells.push_back(sp[i]);
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        rd_err = 0;
        busy_gaps = 0;
        ur_pos.delete();
        fall_pos.delete();
        prev_rd = 1'b1;
    endtask

    task automatic sample(input int n);
        if (rddata !== exp_rd(n)) rd_err++;
        if (underrun === 1'b1) ur_pos.push_back(n);
        if ((prev_rd === 1'b1) && (rddata === 1'b0) && (n < fall_limit)) fall_pos.push_back(n);
        prev_rd = rddata;
    endtask

    task automatic flush();
        enable    = 1'b0;
        nib_valid = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic apply_stimulus(input int v);
        cells.delete();
        push_nib(vecs[v].nib);
`ifdef DRIVE_RDDATA_SYNC_FILL_EN
        push_sync(1);
`endif
        clear_obs();
        fall_limit = 224;
        nib_data   = vecs[v].nib;
        nib_valid  = 1'b1;
        check_output($sformatf("vec%0d_ready", v), nib_ready, 1);
        tick();
        nib_valid = 1'b0;
        for (int n = 0; n < 231; n++) begin
            tick();
            sample(n);
            if (n == 223) check_output($sformatf("vec%0d_busy_last", v), busy, 1);
            if (n == 224) check_output($sformatf("vec%0d_busy_after", v), busy, BUSY_TAIL);
        end
        check_output($sformatf("vec%0d_rddata_cycles_wrong", v), rd_err, 0);
        check_output($sformatf("vec%0d_pulse_count", v), fall_pos.size(), vecs[v].pulses);
        check_output($sformatf("vec%0d_first_pulse", v),
                     (fall_pos.size() > 0) ? fall_pos[0] : -1, 1);
        check_output($sformatf("vec%0d_last_pulse_off", v),
                     (fall_pos.size() > 0) ? fall_pos[fall_pos.size()-1] - fall_pos[0] : -1,
                     vecs[v].last_off);
        check_output($sformatf("vec%0d_underrun_count", v), ur_pos.size(), 1);
        check_output($sformatf("vec%0d_underrun_cycle", v),
                     (ur_pos.size() > 0) ? ur_pos[0] : -1, 223);
        flush();
    endtask

    initial begin
        logic [7:0] seq[3];
        int         idx;
        logic       took;

        _reset    = 1'b0;
        enable    = 1'b0;
        nib_valid = 1'b0;
        nib_data  = 8'h00;
        vecs[0] = '{8'hD5, 5, 196};
        vecs[1] = '{8'hAA, 4, 168};
        vecs[2] = '{8'h96, 4, 168};
        vecs[3] = '{8'hFF, 8, 196};
        vecs[4] = '{8'h80, 1, 0};
        vecs[5] = '{8'h81, 2, 196};

        #12;
        check_output("reset_rddata", rddata, 1);
        check_output("reset_ready", nib_ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_underrun", underrun, 0);
        @(negedge fclk);
        _reset = 1'b1;
        tick();

        // Prefill the holding register while the motor is off.
        nib_data  = 8'hAA;
        nib_valid = 1'b1;
        check_output("prefill_ready", nib_ready, 1);
        tick();
        nib_valid = 1'b0;
        tick();
        tick();
        check_output("prefill_ready_full", nib_ready, 0);
        check_output("prefill_busy", busy, 0);
        check_output("prefill_rddata", rddata, 1);
        enable = 1'b1;
        tick();
        check_output("prefill_load_busy", busy, 1);
        check_output("prefill_load_ready", nib_ready, 1);
        flush();

        for (int v = 0; v < 6; v++) apply_stimulus(v);

        // Back-to-back stream, source valid every cycle.
        seq[0] = 8'hD5;
        seq[1] = 8'hAA;
        seq[2] = 8'h96;
        cells.delete();
        push_nib(seq[0]);
        push_nib(seq[1]);
        push_nib(seq[2]);
`ifdef DRIVE_RDDATA_SYNC_FILL_EN
        push_sync(1);
`endif
        clear_obs();
        fall_limit = 672;
        idx        = 0;
        nib_data   = seq[0];
        nib_valid  = 1'b1;
        for (int k = 0; k < 700; k++) begin
            @(negedge fclk);
            took = nib_valid && nib_ready;
            tick();
            if (took) begin
                idx++;
                if (idx < 3) nib_data = seq[idx];
                else nib_valid = 1'b0;
            end
            if (k >= 1) begin
                sample(k - 1);
                if ((k - 1 <= 671) && (busy !== 1'b1)) busy_gaps++;
            end
        end
        check_output("stream_rddata_cycles_wrong", rd_err, 0);
        check_output("stream_accepted", idx, 3);
        check_output("stream_pulse_count", fall_pos.size(), 13);
        check_output("stream_busy_gaps", busy_gaps, 0);
        check_output("stream_underrun_count", ur_pos.size(), 1);
        check_output("stream_underrun_cycle", (ur_pos.size() > 0) ? ur_pos[0] : -1, 671);
        flush();

`ifdef DRIVE_RDDATA_SYNC_FILL_EN
        // Stall after 0xFF: two sync groups, then 0xD5 arrives mid-group and loads at the group end.
        cells.delete();
        push_nib(8'hFF);
        push_sync(2);
        push_nib(8'hD5);
        push_sync(1);
        clear_obs();
        fall_limit = 0;
        nib_data   = 8'hFF;
        nib_valid  = 1'b1;
        tick();
        nib_valid = 1'b0;
        for (int n = 0; n < 1010; n++) begin
            tick();
            sample(n);
            if (busy !== 1'b1) busy_gaps++;
            if (n == 600) begin
                nib_data  = 8'hD5;
                nib_valid = 1'b1;
            end
            if (n == 601) nib_valid = 1'b0;
        end
        check_output("sync_rddata_cycles_wrong", rd_err, 0);
        check_output("sync_busy_gaps", busy_gaps, 0);
        check_output("sync_underrun_count", ur_pos.size(), 3);
        check_output("sync_underrun_0", (ur_pos.size() > 0) ? ur_pos[0] : -1, 223);
        check_output("sync_underrun_1", (ur_pos.size() > 1) ? ur_pos[1] : -1, 503);
        check_output("sync_underrun_2", (ur_pos.size() > 2) ? ur_pos[2] : -1, 1007);
        flush();
`endif

        // enable drops on the third low cycle of the first pulse; 0x96 waits in holding.
        nib_data  = 8'hFF;
        nib_valid = 1'b1;
        tick();
        nib_data = 8'h96;
        tick();
        nib_valid = 1'b0;
        check_output("bypass_hold_full", nib_ready, 0);
        check_output("bypass_busy", busy, 1);
        repeat (3) tick();
        check_output("drop_pulse_low", rddata, 0);
        enable = 1'b0;
        tick();
        check_output("drop_busy", busy, 0);
        check_output("drop_rddata_n4", rddata, 0);
        repeat (3) tick();
        check_output("drop_rddata_n7", rddata, 0);
        tick();
        check_output("drop_rddata_n8", rddata, 1);
        check_output("drop_hold_kept", nib_ready, 0);
        repeat (2) tick();
        enable = 1'b1;
        tick();
        check_output("resume_busy", busy, 1);
        check_output("resume_ready", nib_ready, 1);
        tick();
        check_output("resume_pulse_cell0", rddata, 0);
        repeat (7) tick();
        check_output("resume_pulse_end", rddata, 1);
        repeat (21) tick();
        check_output("resume_cell1_zero", rddata, 1);
        repeat (56) tick();
        check_output("resume_cell3_one", rddata, 0);
        flush();

        // Asynchronous reset in the middle of a pulse with the holding register full.
        nib_data  = 8'hFF;
        nib_valid = 1'b1;
        tick();
        nib_data = 8'hAA;
        tick();
        nib_valid = 1'b0;
        tick();
        tick();
        check_output("prereset_rddata", rddata, 0);
        check_output("prereset_ready", nib_ready, 0);
        #3;
        _reset = 1'b0;
        #1;
        check_output("async_reset_rddata", rddata, 1);
        check_output("async_reset_ready", nib_ready, 1);
        check_output("async_reset_busy", busy, 0);
        check_output("async_reset_underrun", underrun, 0);
        @(negedge fclk);
        _reset = 1'b1;
        tick();
        tick();
        check_output("postreset_busy", busy, 0);
        check_output("postreset_rddata", rddata, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
